// File: rtl/cordic_prerotate.sv
// cordic_prerotate: quadrant pre-rotation ahead of the CORDIC micro-rotations.
// Each beat is rotated by 0 or +/-90 degrees (exact swap/negate) so the
// following iterations see a vector/angle inside their convergence range.
// quad_o records the rotation applied: 00 none, 01 +90, 11 -90.
//
// Optional feature macro: CORDIC_PREROT_SAT_EN
//   defined   : negating the most negative value saturates to the max positive
//   undefined : negation wraps (plain two's complement)
// z arithmetic always wraps, since the angle is periodic.
//
// Flow control (valid/ready): a beat transfers on any clock edge where its
// valid and the matching ready are both high. Valid never depends on ready.
// in_ready_o comes straight from a register (no path from out_ready_i). The
// output beat holds stable while valid is high and ready is low.
module cordic_prerotate #(
  parameter int N_FRAC = 7,
  localparam int W = N_FRAC + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic [W-1:0] z_i,
  input  logic         mode_i,
  input  logic         data_in_valid_strobe_i,
  output logic         in_ready_o,
  output logic [W-1:0] x_o,
  output logic [W-1:0] y_o,
  output logic [W-1:0] z_o,
  output logic [1:0]   quad_o,
  output logic         mode_o,
  output logic         data_out_valid_strobe_o,
  input  logic         out_ready_i
);

  // Packed beat layout: {mode, quad, z, y, x}
  localparam int BW = 3 * W + 3;

  localparam logic signed [W-1:0] HALF       = W'(2 ** (N_FRAC - 1));
  localparam logic signed [W-1:0] MINUS_HALF = -HALF;
  localparam logic [W-1:0]        MOST_NEG   = {1'b1, {N_FRAC{1'b0}}};
  localparam logic [W-1:0]        MOST_POS   = {1'b0, {N_FRAC{1'b1}}};

  // Negation with the configured treatment of the most negative value
  function automatic logic [W-1:0] neg_f(input logic [W-1:0] v);
`ifdef CORDIC_PREROT_SAT_EN
    if (v == MOST_NEG) neg_f = MOST_POS;
    else               neg_f = -v;
`else
    neg_f = -v;
`endif
  endfunction

  logic signed [W-1:0] xs, ys, zs;
  logic [W-1:0]        xr, yr, zr;
  logic [1:0]          qr;
  logic [BW-1:0]       rot_beat;

  assign xs = $signed(x_i);
  assign ys = $signed(y_i);
  assign zs = $signed(z_i);

  // Pre-rotation of the incoming beat, selected by mode
  always_comb begin
    xr = x_i;
    yr = y_i;
    zr = z_i;
    qr = 2'b00;
    if (!mode_i) begin
      if (zs > HALF) begin
        xr = neg_f(y_i);
        yr = x_i;
        zr = z_i - HALF;
        qr = 2'b01;
      end else if (zs < MINUS_HALF) begin
        xr = y_i;
        yr = neg_f(x_i);
        zr = z_i + HALF;
        qr = 2'b11;
      end
    end else if (xs[W-1]) begin
      if (!ys[W-1]) begin
        xr = y_i;
        yr = neg_f(x_i);
        zr = z_i + HALF;
        qr = 2'b11;
      end else begin
        xr = neg_f(y_i);
        yr = x_i;
        zr = z_i - HALF;
        qr = 2'b01;
      end
    end
  end

  assign rot_beat = {mode_i, qr, zr, yr, xr};

  logic          main_valid_q, main_valid_d;
  logic [BW-1:0] main_q, main_d;
  logic          skid_valid_q, skid_valid_d;
  logic [BW-1:0] skid_q, skid_d;
  logic          in_ready_q;
  logic          accept, drain;

  assign accept = data_in_valid_strobe_i && in_ready_q;
  assign drain  = main_valid_q && out_ready_i;

  // Next state of the main/skid pair; skid only fills behind a stalled main
  always_comb begin
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_d       = rot_beat;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_d       = rot_beat;
    end
  end

  // Buffer registers; ready is held low during reset and rises one cycle after
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign in_ready_o              = in_ready_q;
  assign data_out_valid_strobe_o = main_valid_q;
  assign x_o                     = main_q[W-1:0];
  assign y_o                     = main_q[2*W-1:W];
  assign z_o                     = main_q[3*W-1:2*W];
  assign quad_o                  = main_q[3*W+1:3*W];
  assign mode_o                  = main_q[3*W+2];

endmodule

// File: tb/tb_cordic_prerotate.sv
// Bench for cordic_prerotate (N_FRAC = 7): behavioural reference model with a
// FIFO expected queue, per-cycle compare, directed literal cases and random
// streams with backpressure and mid-stream reset.
module tb_cordic_prerotate;

  localparam int N_FRAC = 7;
  localparam int W = N_FRAC + 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] x_i = '0, y_i = '0, z_i = '0;
  logic         mode_i = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] x_o, y_o, z_o;
  logic [1:0]   quad_o;
  logic         mode_o;
  logic         out_valid;
  logic         out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [26:0] exp_q[$];
  bit          rst_low_prev = 1'b0;
  bit          armed = 1'b0;

  cordic_prerotate #(.N_FRAC(N_FRAC)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .x_i(x_i),
    .y_i(y_i),
    .z_i(z_i),
    .mode_i(mode_i),
    .data_in_valid_strobe_i(in_valid),
    .in_ready_o(in_ready),
    .x_o(x_o),
    .y_o(y_o),
    .z_o(z_o),
    .quad_o(quad_o),
    .mode_o(mode_o),
    .data_out_valid_strobe_o(out_valid),
    .out_ready_i(out_ready)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (plain integer arithmetic) -------------
  function automatic int neg_m(input int v);
    int r;
    r = -v;
    if (r > 127) begin
`ifdef CORDIC_PREROT_SAT_EN
      r = 127;
`else
      r = r - 256;
`endif
    end
    return r;
  endfunction

  function automatic int wrap_m(input int v);
    int r;
    r = v;
    if (r > 127)  r = r - 256;
    if (r < -128) r = r + 256;
    return r;
  endfunction

  // returns {mode, quad, z, y, x}
  function automatic logic [26:0] ref_model(input int x, input int y, input int z, input bit mode);
    int xo, yo, zo;
    logic [1:0] q;
    logic [7:0] xb, yb, zb;
    xo = x; yo = y; zo = z; q = 2'b00;
    if (!mode) begin
      if (z > 64) begin
        xo = neg_m(y); yo = x; zo = z - 64; q = 2'b01;
      end else if (z < -64) begin
        xo = y; yo = neg_m(x); zo = z + 64; q = 2'b11;
      end
    end else if (x < 0) begin
      if (y >= 0) begin
        xo = y; yo = neg_m(x); zo = z + 64; q = 2'b11;
      end else begin
        xo = neg_m(y); yo = x; zo = z - 64; q = 2'b01;
      end
    end
    zo = wrap_m(zo);
    xb = 8'(xo); yb = 8'(yo); zb = 8'(zo);
    return {mode, q, zb, yb, xb};
  endfunction

  // ---------------- scoreboard: compare every cycle at negedge ------------
  always @(negedge clk) begin
    bit exp_rdy;
    if (!rst) begin
      if (rst_low_prev) begin
        chk("rst_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_outs", {5'd0, mode_o, quad_o, z_o, y_o, x_o}, 32'd0);
      end
      exp_q.delete();
      rst_low_prev = 1'b1;
      armed = 1'b1;
    end else if (armed) begin
      exp_rdy = rst_low_prev ? 1'b0 : (exp_q.size() < 2);
      chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0)
        chk("out_beat", {5'd0, mode_o, quad_o, z_o, y_o, x_o}, {5'd0, exp_q[0]});
      else if (rst_low_prev)
        chk("post_rst_outs", {5'd0, mode_o, quad_o, z_o, y_o, x_o}, 32'd0);
      if (exp_q.size() > 0 && out_ready) void'(exp_q.pop_front());
      if (in_valid && exp_rdy)
        exp_q.push_back(ref_model($signed(x_i), $signed(y_i), $signed(z_i), mode_i));
      rst_low_prev = 1'b0;
    end
  end

  // ---------------- driver tasks ------------------------------------------
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      out_ready = 1'b1;
    end
  endtask

  // One beat on an idle path, checked against hand-computed literals
  task automatic directed(input string name, input int x, input int y, input int z, input bit mode,
                          input int ex, input int ey, input int ez, input logic [1:0] eq);
    @(posedge clk); #1;
    x_i = 8'(x); y_i = 8'(y); z_i = 8'(z); mode_i = mode;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk({name, "_acc"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({name, "_v"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_x"}, {24'd0, x_o}, {24'd0, 8'(ex)});
    chk({name, "_y"}, {24'd0, y_o}, {24'd0, 8'(ey)});
    chk({name, "_z"}, {24'd0, z_o}, {24'd0, 8'(ez)});
    chk({name, "_q"}, {30'd0, quad_o}, {30'd0, eq});
  endtask

  // ready_kind: 0 stall cycles 2..5, 1 random, 2 always ready, 3 never ready
  task automatic run_stream(input int ncyc, input int nbeats, input int ready_kind, input int valid_pct);
    int sent;
    int edge_v[6];
    edge_v = '{-128, 127, 64, -64, 65, -65};
    sent = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (sent < nbeats && $urandom_range(99) < valid_pct) begin
        in_valid = 1'b1;
        x_i = ($urandom_range(3) == 0) ? 8'(edge_v[$urandom_range(5)]) : 8'($urandom_range(255));
        y_i = ($urandom_range(3) == 0) ? 8'(edge_v[$urandom_range(5)]) : 8'($urandom_range(255));
        z_i = ($urandom_range(3) == 0) ? 8'(edge_v[$urandom_range(5)]) : 8'($urandom_range(255));
        mode_i = 1'($urandom_range(1));
      end else begin
        in_valid = 1'b0;
      end
      case (ready_kind)
        0: out_ready = !(c >= 2 && c <= 5);
        1: out_ready = ($urandom_range(99) < 65);
        2: out_ready = 1'b1;
        default: out_ready = 1'b0;
      endcase
      @(negedge clk);
      if (in_valid && in_ready) sent++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // ---------------- main sequence -----------------------------------------
  initial begin
    logic [26:0] m;
    // model pinned by hand-computed literals
    m = ref_model(100, 20, 96, 1'b0);
    chk("model_rot_pos", {5'd0, m}, {5'd0, 1'b0, 2'b01, 8'd32, 8'd100, 8'hEC});
    m = ref_model(-50, 30, 100, 1'b1);
    chk("model_vec_wrap", {5'd0, m}, {5'd0, 1'b1, 2'b11, 8'hA4, 8'd50, 8'd30});
    m = ref_model(0, -5, 10, 1'b1);
    chk("model_vec_pass", {5'd0, m}, {5'd0, 1'b1, 2'b00, 8'd10, 8'hFB, 8'd0});

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle(2);

    directed("rot_p90",  100, 20, 96, 1'b0, -20, 100, 32, 2'b01);
    directed("rot_m90",  100, 20, -96, 1'b0, 20, -100, -32, 2'b11);
    directed("rot_half", 100, 20, 64, 1'b0, 100, 20, 64, 2'b00);
    directed("rot_mhalf", 100, 20, -64, 1'b0, 100, 20, -64, 2'b00);
    directed("vec_q2",   -50, 30, 10, 1'b1, 30, 50, 74, 2'b11);
    directed("vec_q3",   -50, -30, 10, 1'b1, 30, -50, -54, 2'b01);
    directed("vec_pass", 0, -5, 10, 1'b1, 0, -5, 10, 2'b00);
`ifdef CORDIC_PREROT_SAT_EN
    directed("sat_neg",  10, -128, 100, 1'b0, 127, 10, 36, 2'b01);
`else
    directed("sat_neg",  10, -128, 100, 1'b0, -128, 10, 36, 2'b01);
`endif
    directed("wrap_p",   3, 4, 127, 1'b0, -4, 3, 63, 2'b01);
    directed("wrap_m",   3, 4, -127, 1'b0, 4, -3, -63, 2'b11);
    directed("wrap_vec", -7, 9, 100, 1'b1, 9, 7, -92, 2'b11);
    idle(2);

    // backpressure: 6 beats, output stalled cycles 2..5
    run_stream(20, 6, 0, 100);
    idle(4);

    // reset mid-stream with both entries full
    run_stream(4, 3, 3, 100);
    @(posedge clk); #1;
    out_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    idle(5);

    // random traffic
    run_stream(600, 1000, 1, 70);
    run_stream(300, 1000, 2, 100);
    run_stream(300, 1000, 1, 90);
    idle(6);

    chk("drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
